// File: rtl/rtc_display_scheduler_pkg.sv
// Shared constants and types for the RTC display scheduler.
// Holds sweep addresses, FSM encoding and reset defaults.
package rtc_pkg;

  localparam logic [7:0] RTC_ADDR_SEG  = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
  localparam logic [7:0] RTC_ADDR_HORA = 8'h23;
  localparam logic [7:0] RTC_ADDR_DIA  = 8'h24;
  localparam logic [7:0] RTC_ADDR_MES  = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR = 8'h26;

  localparam int NUM_SWEEP_REGS = 6;

  localparam logic [7:0] RST_DIA = 8'h01;
  localparam logic [7:0] RST_MES = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    NEXT,
    CWAIT
  } state_t;

  function automatic logic [7:0] sweep_addr(
    input logic [2:0] idx
  );
    logic [7:0] a;
    a = RTC_ADDR_SEG;
    unique case (1'b1)
      (idx == 3'd1): a = RTC_ADDR_MIN;
      (idx == 3'd2): a = RTC_ADDR_HORA;
      (idx == 3'd3): a = RTC_ADDR_DIA;
      (idx == 3'd4): a = RTC_ADDR_MES;
      (idx == 3'd5): a = RTC_ADDR_YEAR;
      default:       a = RTC_ADDR_SEG;
    endcase
    return a;
  endfunction

  // Slot 3 is day, slot 4 is month; both reset to 01.
  function automatic logic [7:0] rst_val(input int i);
    if (i == 3) return RST_DIA;
    if (i == 4) return RST_MES;
    return 8'h00;
  endfunction

endpackage

// File: rtl/rtc_display_scheduler_if.sv
// RTC register read bus: request/address out, ack/data back.
// The scheduler is the master; the RTC bus block is the slave.
interface rtc_display_scheduler_if;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface

// File: rtl/rtc_display_scheduler_vsync_edge_det.sv
// Falling-edge detector for the active-low VGA vsync pulse.
// Delays vsync by one register and flags the 1->0 step.
module vsync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_fall
);

  logic r_vsync_d;

  // Reset low so a vsync held low across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) r_vsync_d <= 1'b0;
    else       r_vsync_d <= i_vsync;
  end

  assign o_fall = r_vsync_d & ~i_vsync;

endmodule

// File: rtl/rtc_display_scheduler.sv
// Sweeps the six RTC time/date registers into shadows and
// commits them to the VGA text path on a vsync falling edge.
module rtc_display_scheduler
  import rtc_pkg::*;
#(
  parameter int REFRESH_TICKS = 5_000_000,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       edit_hold,
  rtc_display_scheduler_if.master bus,
  output logic [7:0] seg_c,
  output logic [7:0] min_c,
  output logic [7:0] hora_c,
  output logic [7:0] cambio_dia,
  output logic [7:0] cambio_mes,
  output logic [7:0] cambio_year,
  output logic       update_pulse,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CNT_W = $clog2(REFRESH_TICKS);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [TMO_W-1:0] r_tmo;
  logic             r_abort;
  logic             r_req;
  logic [7:0]       r_addr;
  logic             r_pulse;
  logic             r_busy;
  logic             r_terr;
  logic [7:0]       r_sh  [NUM_SWEEP_REGS];
  logic [7:0]       r_out [NUM_SWEEP_REGS];
  logic [CNT_W-1:0] r_cnt;

  logic w_tc;
  logic w_fall;

  vsync_edge_det u_vs (
    .clk     (clk),
    .reset   (reset),
    .i_vsync (vsync),
    .o_fall  (w_fall)
  );

  assign w_tc = (r_cnt == CNT_W'(REFRESH_TICKS - 1));

  // Free-running; a terminal count outside IDLE is simply lost.
  always_ff @(posedge clk) begin
    if (reset || w_tc) r_cnt <= '0;
    else               r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_abort <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
      for (int i = 0; i < NUM_SWEEP_REGS; i++) begin
        r_sh[i]  <= rst_val(i);
        r_out[i] <= rst_val(i);
      end
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_tc && !edit_hold) begin
            r_state <= REQ;
            r_idx   <= '0;
            r_abort <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        REQ: begin
          r_req   <= 1'b1;
          r_addr  <= sweep_addr(r_idx);
          r_tmo   <= '0;
          r_state <= WAIT;
          if (edit_hold) r_abort <= 1'b1;
        end
        WAIT: begin
          if (edit_hold) r_abort <= 1'b1;
          // An ack arriving with the last timeout cycle still counts.
          if (bus.rd_ack) begin
            r_sh[r_idx] <= bus.rd_data;
            r_tmo       <= '0;
            r_req       <= 1'b0;
            r_state     <= NEXT;
          end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
            r_req   <= 1'b0;
            r_terr  <= 1'b1;
            r_tmo   <= '0;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        NEXT: begin
          if (r_abort || edit_hold) begin
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_idx == 3'(NUM_SWEEP_REGS - 1)) begin
            r_state <= CWAIT;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= REQ;
          end
        end
        CWAIT: begin
          if (edit_hold) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_fall) begin
            for (int i = 0; i < NUM_SWEEP_REGS; i++)
              r_out[i] <= r_sh[i];
            r_pulse <= 1'b1;
            r_terr  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_req   = r_req;
  assign bus.rd_addr  = r_addr;
  assign seg_c        = r_out[0];
  assign min_c        = r_out[1];
  assign hora_c       = r_out[2];
  assign cambio_dia   = r_out[3];
  assign cambio_mes   = r_out[4];
  assign cambio_year  = r_out[5];
  assign update_pulse = r_pulse;
  assign busy         = r_busy;
  assign timeout_err  = r_terr;

endmodule

// File: doc/rtc_display_scheduler.md
Name: rtc_display_scheduler

Overview:
- Sequences periodic read sweeps of the six RTC time/date registers over the RTC read handshake bus.
- Stages the results in shadow registers, then commits them to the BCD display inputs of the VGA text path (seg_c, min_c, hora_c, cambio_dia, cambio_mes, cambio_year).
- Commits only at the start of vertical sync, so a frame never shows a half-updated time.
- Sits between the RTC bus interface and the VGA block; it suppresses commits while the user is editing.

Parameters:
- REFRESH_TICKS, 5_000_000, clk cycles from one sweep start to the next (100 ms at 50 MHz).
- ACK_TIMEOUT, 255, max clk cycles rd_req may wait for rd_ack before the sweep aborts.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- vsync  in  1  VGA vsync, active-low pulse, synchronous to clk
- edit_hold  in  1  user edit mode active; blocks sweep start and commit
- rd_ack  in  1  RTC bus: rd_data valid, transaction done
- rd_data  in  8  RTC bus read data, BCD
- rd_req  out  1  RTC bus read request
- rd_addr  out  8  RTC register address
- seg_c, min_c, hora_c  out  8 each  committed BCD seconds/minutes/hours
- cambio_dia, cambio_mes, cambio_year  out  8 each  committed BCD day/month/year
- update_pulse  out  1  one-cycle strobe on commit
- busy  out  1  sweep or commit-wait in progress
- timeout_err  out  1  sticky; last sweep aborted on timeout

Behaviour:
Reset values:
- seg_c/min_c/hora_c/cambio_year = 8'h00; cambio_dia/cambio_mes = 8'h01.
- rd_req=0, rd_addr=8'h00, update_pulse=0, busy=0, timeout_err=0.
- Refresh counter=0, FSM=IDLE, shadow regs cleared to the same values as the outputs.

Refresh counter:
- Free-runs 0..REFRESH_TICKS-1.
- Terminal count while FSM=IDLE and edit_hold=0: start sweep and reset counter.
- Terminal count while busy or edit_hold=1: ignored; counter wraps, no sweep queued.

Sweep order, index 0..5 → address:
- seconds 8'h21, minutes 8'h22, hours 8'h23, day 8'h24, month 8'h25, year 8'h26.

FSM states:
- IDLE: wait for sweep start.
- REQ: drive rd_addr=ADDR[idx] and rd_req=1 (registered). Go to WAIT.
- WAIT:
  - rd_req held high and rd_addr stable.
  - If rd_ack=1: capture rd_data into shadow[idx], clear the timeout counter, drop rd_req the next cycle. Go to NEXT.
  - If the timeout counter reaches ACK_TIMEOUT: drop rd_req, set timeout_err=1, discard shadows. Go to IDLE.
- NEXT: if idx=5, go to CWAIT; else idx+1 and go to REQ. This gives one idle bus cycle between transactions.
- CWAIT:
  - Wait for a vsync falling edge (vsync_d=1, vsync=0; vsync_d is a 1-cycle delayed register).
  - On that edge, copy all six shadows to the outputs in the same cycle, pulse update_pulse for 1 cycle, clear timeout_err. Go to IDLE.

Bus handshake:
- rd_ack is honoured only in WAIT.
- rd_ack in any other state is ignored.

edit_hold:
- If it rises during REQ/WAIT/NEXT, the current bus transaction still completes normally (no aborted handshake). The sweep is then abandoned and the FSM goes to IDLE.
- High in CWAIT: shadows discarded, go to IDLE, no commit.

Simultaneous events:
- rd_ack on the same cycle as timeout: ack wins.
- vsync edge on the same cycle as edit_hold=1: hold wins.

busy:
- 1 in every state except IDLE.

Latency:
- Sweep start to CWAIT entry = 6×(2+ack_wait) + 6 cycles, where ack_wait is cycles from rd_req high to rd_ack.
- Commit occurs at the first vsync fall after CWAIT entry; worst case one frame (~16.7 ms).

Data:
- No BCD validation; rd_data is passed through unchanged.

Mid-operation reset:
- rd_req low on the cycle after reset is sampled.
- All state returns to reset values.

Decomposition:
- Shared package rtc_pkg holds:
  - address constants RTC_ADDR_SEG..RTC_ADDR_YEAR;
  - NUM_SWEEP_REGS=6;
  - FSM state encodings (IDLE, REQ, WAIT, NEXT, CWAIT);
  - reset defaults for day and month (8'h01).
- One natural sub-module: vsync_edge_det (registered falling-edge detector); all other logic stays in this module.

Test Plan:
- Reset, then sweep with 2-cycle ack latency; RTC returns 8'h45, 8'h30, 8'h12, 8'h24, 8'h04, 8'h16 → outputs unchanged until the vsync fall, then seg_c=45, min_c=30, hora_c=12, cambio_dia=24, cambio_mes=04, cambio_year=16, update_pulse high for exactly 1 cycle.
- rd_ack withheld on address 8'h23 → after 255 cycles rd_req drops, timeout_err=1, outputs keep the previous values; the next good sweep commits and clears timeout_err.
- edit_hold raised while WAIT on address 8'h22 → transaction finishes, no REQ for 8'h23, busy=0, no update_pulse at the next vsync.
- edit_hold=1 in CWAIT on the same cycle as the vsync fall → no commit, FSM=IDLE.
- Reset asserted during WAIT → rd_req=0 the next cycle, cambio_dia=01, cambio_mes=01, all other outputs 00.
- REFRESH_TICKS=50, ack held off 60 cycles per read → terminal count ignored while busy; sweeps never overlap and rd_addr runs 21..26 in strict order.
